// File: rtl/dual_channel_arbiter.sv
// Dual-channel rotating-priority arbiter.
// Up to two level-sensitive requesters own the two shared channels at once.
// Each grant lasts while its owner keeps requesting, up to MAX_HOLD cycles.
module dual_channel_arbiter #(
    parameter int REQ_WIDTH = 12,
    parameter int MAX_HOLD  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [REQ_WIDTH-1:0]         req,
    output logic                         gnt0_valid,
    output logic [$clog2(REQ_WIDTH)-1:0] gnt0_id,
    output logic                         gnt1_valid,
    output logic [$clog2(REQ_WIDTH)-1:0] gnt1_id,
    output logic [REQ_WIDTH-1:0]         gnt_vec,
    output logic [1:0]                   timeout
);

    localparam int IW = $clog2(REQ_WIDTH);
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(REQ_WIDTH - 1);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
    localparam bit            HOLD_EN    = (MAX_HOLD != 0);

    typedef enum logic {IDLE, BUSY} ch_state_t;

    ch_state_t      state0, state1;
    logic [IW-1:0]  id0, id1;
    logic [CW-1:0]  cnt0, cnt1;
    logic [IW-1:0]  ptr;

    logic [REQ_WIDTH-1:0] eligible;
    logic                 first_found, second_found;
    logic [IW-1:0]        first_idx, second_idx;
    logic [IW-1:0]        scan_idx;
    int                   scan_pos;

    logic                 release0, release1, expire0, expire1;
    logic                 assign0, assign1;
    logic [IW-1:0]        new0, new1;
    logic [IW-1:0]        ptr_k;
    logic [REQ_WIDTH-1:0] vec_next;

    assign gnt0_valid = (state0 == BUSY);
    assign gnt1_valid = (state1 == BUSY);
    assign gnt0_id    = id0;
    assign gnt1_id    = id1;

    // Walk the rotated priority order (ptr downwards with wrap) and pick the
    // top two requesters that do not already own a channel.
    always_comb begin
        eligible = req;
        if (state0 == BUSY) eligible[id0] = 1'b0;
        if (state1 == BUSY) eligible[id1] = 1'b0;
        first_found  = 1'b0;
        second_found = 1'b0;
        first_idx    = '0;
        second_idx   = '0;
        scan_pos     = 0;
        scan_idx     = '0;
        for (int off = 0; off < REQ_WIDTH; off++) begin
            scan_pos = int'(ptr) - off;
            if (scan_pos < 0) scan_pos = scan_pos + REQ_WIDTH;
            scan_idx = IW'(scan_pos);
            if (eligible[scan_idx]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_idx   = scan_idx;
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_idx   = scan_idx;
                end
            end
        end
    end

    // Decide releases, hold-limit revokes and new assignments; only channels
    // already idle at the start of the cycle can take a new owner.
    always_comb begin
        expire0  = (state0 == BUSY) && req[id0] && HOLD_EN && (cnt0 == HOLD_LIMIT);
        expire1  = (state1 == BUSY) && req[id1] && HOLD_EN && (cnt1 == HOLD_LIMIT);
        release0 = (state0 == BUSY) && (!req[id0] || expire0);
        release1 = (state1 == BUSY) && (!req[id1] || expire1);
        assign0  = 1'b0;
        assign1  = 1'b0;
        new0     = first_idx;
        new1     = first_idx;
        ptr_k    = first_idx;
        if (state0 == IDLE && state1 == IDLE) begin
            assign0 = first_found;
            new0    = first_idx;
            assign1 = second_found;
            new1    = second_idx;
            if (second_found) ptr_k = second_idx;
        end else if (state0 == IDLE) begin
            assign0 = first_found;
            new0    = first_idx;
        end else if (state1 == IDLE) begin
            assign1 = first_found;
            new1    = first_idx;
        end
        vec_next = '0;
        if (state0 == BUSY && !release0) vec_next[id0]  = 1'b1;
        if (state1 == BUSY && !release1) vec_next[id1]  = 1'b1;
        if (assign0)                     vec_next[new0] = 1'b1;
        if (assign1)                     vec_next[new1] = 1'b1;
    end

    // Channel state machines, hold counters, rotation pointer and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state0  <= IDLE;
            state1  <= IDLE;
            id0     <= '0;
            id1     <= '0;
            cnt0    <= '0;
            cnt1    <= '0;
            ptr     <= LAST_IDX;
            gnt_vec <= '0;
            timeout <= 2'b00;
        end else begin
            case (state0)
                IDLE: if (assign0) begin
                    state0 <= BUSY;
                    id0    <= new0;
                    cnt0   <= CW'(1);
                end
                BUSY: if (release0) begin
                    state0 <= IDLE;
                    cnt0   <= '0;
                end else if (HOLD_EN && cnt0 != HOLD_LIMIT) begin
                    cnt0 <= cnt0 + 1'b1;
                end
                default: state0 <= IDLE;
            endcase
            case (state1)
                IDLE: if (assign1) begin
                    state1 <= BUSY;
                    id1    <= new1;
                    cnt1   <= CW'(1);
                end
                BUSY: if (release1) begin
                    state1 <= IDLE;
                    cnt1   <= '0;
                end else if (HOLD_EN && cnt1 != HOLD_LIMIT) begin
                    cnt1 <= cnt1 + 1'b1;
                end
                default: state1 <= IDLE;
            endcase
            if (assign0 || assign1) begin
                ptr <= (ptr_k == '0) ? LAST_IDX : ptr_k - 1'b1;
            end
            gnt_vec <= vec_next;
            timeout <= {expire1, expire0};
        end
    end

endmodule

// File: tb/tb_dual_channel_arbiter.sv
// Scoreboard bench for dual_channel_arbiter: directed stimulus pushes
// hand-computed expectations tagged with the edge they apply to, and a
// negedge monitor pops and compares them against two DUT instances
// (MAX_HOLD=8 and MAX_HOLD=0) that share clock, reset and req.
module tb_dual_channel_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] req;

    logic        a_v0, a_v1, b_v0, b_v1;
    logic [3:0]  a_id0, a_id1, b_id0, b_id1;
    logic [11:0] a_vec, b_vec;
    logic [1:0]  a_to, b_to;

    typedef struct {
        int          tag;
        int          inst;
        string       name;
        logic        v0;
        logic [3:0]  id0;
        logic        v1;
        logic [3:0]  id1;
        logic [11:0] vec;
        logic [1:0]  to;
        bit          id_all;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt   = 0;
    int   n_compared = 0;
    int   n_mismatch = 0;

    dual_channel_arbiter #(.REQ_WIDTH(12), .MAX_HOLD(8)) dut_a (
        .clk(clk), .reset(reset), .req(req),
        .gnt0_valid(a_v0), .gnt0_id(a_id0), .gnt1_valid(a_v1), .gnt1_id(a_id1),
        .gnt_vec(a_vec), .timeout(a_to)
    );

    dual_channel_arbiter #(.REQ_WIDTH(12), .MAX_HOLD(0)) dut_b (
        .clk(clk), .reset(reset), .req(req),
        .gnt0_valid(b_v0), .gnt0_id(b_id0), .gnt1_valid(b_v1), .gnt1_id(b_id1),
        .gnt_vec(b_vec), .timeout(b_to)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Queue an expectation for the outputs after the next rising edge.
    task automatic pushExp(input int inst, input string name,
                           input logic v0, input logic [3:0] id0,
                           input logic v1, input logic [3:0] id1,
                           input logic [11:0] vec, input logic [1:0] to,
                           input bit id_all);
        exp_t e;
        e.tag = edge_cnt + 1; e.inst = inst; e.name = name;
        e.v0 = v0; e.id0 = id0; e.v1 = v1; e.id1 = id1;
        e.vec = vec; e.to = to; e.id_all = id_all;
        sb.push_back(e);
    endtask

    // Drive inputs for one cycle and move just past the next rising edge.
    task automatic applyStimulus(input logic r, input logic [11:0] q);
        reset = r;
        req   = q;
        @(posedge clk);
        #1;
    endtask

    // Compare one expectation against the selected instance.
    task automatic checkOutput(input exp_t e);
        logic        v0, v1;
        logic [3:0]  id0, id1;
        logic [11:0] vec;
        logic [1:0]  to;
        logic [29:0] act, req_v;
        if (e.inst == 0) begin
            v0 = a_v0; id0 = a_id0; v1 = a_v1; id1 = a_id1; vec = a_vec; to = a_to;
        end else begin
            v0 = b_v0; id0 = b_id0; v1 = b_v1; id1 = b_id1; vec = b_vec; to = b_to;
        end
        if (!(e.v0 || e.id_all)) id0 = 4'd0;
        if (!(e.v1 || e.id_all)) id1 = 4'd0;
        act   = {v0, id0, v1, id1, vec, to};
        req_v = {e.v0, (e.v0 || e.id_all) ? e.id0 : 4'd0,
                 e.v1, (e.v1 || e.id_all) ? e.id1 : 4'd0, e.vec, e.to};
        n_compared++;
        if (act !== req_v) begin
            n_mismatch++;
            $display("[TB] FAIL %s inst%0d edge%0d: got v0=%b id0=%0d v1=%b id1=%0d vec=%h to=%b, want v0=%b id0=%0d v1=%b id1=%0d vec=%h to=%b",
                     e.name, e.inst, e.tag, v0, id0, v1, id1, vec, to,
                     e.v0, e.id0, e.v1, e.id1, e.vec, e.to);
        end
    endtask

    // Monitor: pop every expectation that belongs to the current edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= edge_cnt) begin
            exp_t e;
            e = sb.pop_front();
            if (e.tag < edge_cnt) begin
                n_compared++;
                n_mismatch++;
                $display("[TB] FAIL %s stale: checked at edge%0d, wanted edge%0d", e.name, edge_cnt, e.tag);
            end else begin
                checkOutput(e);
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        reset = 1'b1;
        req   = '0;

        // Reset held with every requester active.
        pushExp(0, "reset1", 0, 0, 0, 0, 12'h000, 2'b00, 1);
        applyStimulus(1, 12'hFFF);
        pushExp(0, "reset2", 0, 0, 0, 0, 12'h000, 2'b00, 1);
        pushExp(1, "reset2", 0, 0, 0, 0, 12'h000, 2'b00, 1);
        applyStimulus(1, 12'hFFF);
        pushExp(0, "post_reset", 1, 11, 1, 10, 12'hC00, 2'b00, 0);
        applyStimulus(0, 12'hFFF);
        pushExp(0, "re_reset", 0, 0, 0, 0, 12'h000, 2'b00, 1);
        applyStimulus(1, 12'h000);

        // Dual grant then release and reuse.
        pushExp(0, "dual_grant", 1, 7, 1, 5, 12'h0A0, 2'b00, 0);
        applyStimulus(0, 12'h0A4);
        pushExp(0, "dual_hold", 1, 7, 1, 5, 12'h0A0, 2'b00, 0);
        applyStimulus(0, 12'h0A4);
        pushExp(0, "release7", 0, 0, 1, 5, 12'h020, 2'b00, 0);
        applyStimulus(0, 12'h024);
        pushExp(0, "reuse_ch0", 1, 2, 1, 5, 12'h024, 2'b00, 0);
        applyStimulus(0, 12'h024);

        // Wrap-around from ptr=1, then confirm ptr landed on 10.
        pushExp(0, "release_all", 0, 0, 0, 0, 12'h000, 2'b00, 0);
        applyStimulus(0, 12'h000);
        pushExp(0, "wrap", 1, 0, 1, 11, 12'h801, 2'b00, 0);
        applyStimulus(0, 12'h801);
        pushExp(0, "idle", 0, 0, 0, 0, 12'h000, 2'b00, 0);
        applyStimulus(0, 12'h000);
        pushExp(0, "ptr10", 1, 10, 1, 11, 12'hC00, 2'b00, 0);
        applyStimulus(0, 12'hC00);
        pushExp(0, "idle2", 0, 0, 0, 0, 12'h000, 2'b00, 0);
        pushExp(1, "idle2", 0, 0, 0, 0, 12'h000, 2'b00, 0);
        applyStimulus(0, 12'h000);

        // Hold limit: eight valid cycles, revoke pulse, re-grant.
        for (int i = 0; i < 8; i++) begin
            pushExp(0, "hold", 1, 3, 0, 0, 12'h008, 2'b00, 0);
            pushExp(1, "nohold", 1, 3, 0, 0, 12'h008, 2'b00, 0);
            applyStimulus(0, 12'h008);
        end
        pushExp(0, "revoke", 0, 0, 0, 0, 12'h000, 2'b01, 0);
        pushExp(1, "no_revoke", 1, 3, 0, 0, 12'h008, 2'b00, 0);
        applyStimulus(0, 12'h008);
        pushExp(0, "regrant", 1, 3, 0, 0, 12'h008, 2'b00, 0);
        pushExp(1, "no_revoke2", 1, 3, 0, 0, 12'h008, 2'b00, 0);
        applyStimulus(0, 12'h008);
        pushExp(0, "regrant_hold", 1, 3, 0, 0, 12'h008, 2'b00, 0);
        applyStimulus(0, 12'h008);

        // Second channel joins; reset lands exactly where ch0 would expire.
        for (int i = 0; i < 6; i++) begin
            pushExp(0, "both_busy", 1, 3, 1, 7, 12'h088, 2'b00, 0);
            applyStimulus(0, 12'h088);
        end
        pushExp(0, "mid_reset", 0, 0, 0, 0, 12'h000, 2'b00, 1);
        pushExp(1, "mid_reset", 0, 0, 0, 0, 12'h000, 2'b00, 1);
        applyStimulus(1, 12'h088);
        pushExp(0, "after_mid_reset", 1, 11, 1, 10, 12'hC00, 2'b00, 0);
        pushExp(1, "after_mid_reset", 1, 11, 1, 10, 12'hC00, 2'b00, 0);
        applyStimulus(0, 12'hFFF);
        applyStimulus(0, 12'h000);

        @(negedge clk);
        @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL %s never checked: wanted edge%0d, now edge%0d", e.name, e.tag, edge_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
